// File: rtl/vga_pkg.sv
`default_nettype none
// ============================================================================
// Module   : vga_pkg
// Purpose  : Shared definitions for the VGA mode controller: mode codes,
//            per-mode timing constants, FSM state encoding and small helpers.
// Revision : 1.0 - initial release
// ============================================================================
package vga_pkg;

  // Mode codes, also used directly as the PLL/mux select value
  localparam logic [1:0] MODE_640     = 2'd0;
  localparam logic [1:0] MODE_800     = 2'd1;
  localparam logic [1:0] MODE_1024    = 2'd2;
  localparam logic [1:0] MODE_ILLEGAL = 2'd3;

  localparam int CNT_W = 17;

  typedef enum logic [2:0] {
    ST_RUN      = 3'd0,
    ST_DRAIN    = 3'd1,
    ST_SWITCH   = 3'd2,
    ST_LOCK     = 3'd3,
    ST_SETTLE   = 3'd4,
    ST_BLANKING = 3'd5
  } vga_state_e;

  typedef struct packed {
    logic [10:0] h_sync;
    logic [10:0] h_back;
    logic [10:0] h_active;
    logic [10:0] h_front;
    logic [10:0] v_sync;
    logic [10:0] v_back;
    logic [10:0] v_active;
    logic [10:0] v_front;
  } vga_timing_t;

  localparam vga_timing_t TIMING_640 = '{
    h_sync: 11'd96,  h_back: 11'd48,  h_active: 11'd640,  h_front: 11'd16,
    v_sync: 11'd2,   v_back: 11'd33,  v_active: 11'd480,  v_front: 11'd10
  };
  localparam vga_timing_t TIMING_800 = '{
    h_sync: 11'd128, h_back: 11'd88,  h_active: 11'd800,  h_front: 11'd40,
    v_sync: 11'd4,   v_back: 11'd23,  v_active: 11'd600,  v_front: 11'd1
  };
  localparam vga_timing_t TIMING_1024 = '{
    h_sync: 11'd136, h_back: 11'd160, h_active: 11'd1024, h_front: 11'd24,
    v_sync: 11'd6,   v_back: 11'd29,  v_active: 11'd768,  v_front: 11'd3
  };

  // Timing lookup; the illegal code never reaches the outputs (requests for
  // it are rejected), so it simply falls back to the 640x480 set.
  function automatic vga_timing_t mode_timing(input logic [1:0] mode);
    case (mode)
      MODE_800:  return TIMING_800;
      MODE_1024: return TIMING_1024;
      default:   return TIMING_640;
    endcase
  endfunction

  // Saturating increment: counters stick at all-ones rather than wrapping
  function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
    return (&v) ? v : v + 1'b1;
  endfunction

endpackage
`default_nettype wire

// File: rtl/vga_mode_table.sv
`default_nettype none
// ============================================================================
// Module   : vga_mode_table
// Purpose  : Combinational mode-code to display-timing lookup.
// Revision : 1.0 - initial release
// ============================================================================
module vga_mode_table
  import vga_pkg::*;
(
  input  logic [1:0]  i_mode,
  output logic [10:0] o_h_sync,
  output logic [10:0] o_h_back,
  output logic [10:0] o_h_active,
  output logic [10:0] o_h_front,
  output logic [10:0] o_v_sync,
  output logic [10:0] o_v_back,
  output logic [10:0] o_v_active,
  output logic [10:0] o_v_front
);

  vga_timing_t w_tim;

  // Pure table lookup from the shared package
  always_comb begin
    w_tim = mode_timing(i_mode);
  end

  assign o_h_sync   = w_tim.h_sync;
  assign o_h_back   = w_tim.h_back;
  assign o_h_active = w_tim.h_active;
  assign o_h_front  = w_tim.h_front;
  assign o_v_sync   = w_tim.v_sync;
  assign o_v_back   = w_tim.v_back;
  assign o_v_active = w_tim.v_active;
  assign o_v_front  = w_tim.v_front;

endmodule
`default_nettype wire

// File: rtl/vga_mode_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : vga_mode_ctrl
// Purpose  : Video mode switch sequencer. Drains the current frame, retunes
//            the pixel-clock PLL, waits for lock and settle time, then blanks
//            a number of frames before releasing the new mode.
// Options  : VGA_MODE_CTRL_TIMEOUT_EN - abandon LOCK after LOCK_TIMEOUT
//            cycles, flag err and fall back to RESET_MODE.
// Revision : 1.0 - initial release
// ============================================================================
module vga_mode_ctrl
  import vga_pkg::*;
#(
  parameter int LOCK_TIMEOUT  = 65000,
  parameter int SETTLE_CYCLES = 256,
  parameter int BLANK_FRAMES  = 2,
  parameter int RESET_MODE    = 2
) (
  input  logic        vga_clk,
  input  logic        rst_n,
  input  logic [1:0]  req_mode,
  input  logic        req_valid,
  output logic        req_ready,
  input  logic        frame_end,
  input  logic        pll_locked,
  output logic [1:0]  clk_sel,
  output logic        timing_en,
  output logic        blank,
  output logic [10:0] h_sync,
  output logic [10:0] h_back,
  output logic [10:0] h_active,
  output logic [10:0] h_front,
  output logic [10:0] v_sync,
  output logic [10:0] v_back,
  output logic [10:0] v_active,
  output logic [10:0] v_front,
  output logic [1:0]  cur_mode,
  output logic        busy,
  output logic        err
);

  localparam logic [1:0]       c_reset_mode  = 2'(RESET_MODE);
  localparam logic [CNT_W-1:0] c_switch_last = 17'd15;
  localparam logic [CNT_W-1:0] c_settle_last = CNT_W'(SETTLE_CYCLES - 1);
  localparam logic [CNT_W-1:0] c_blank_last  = CNT_W'(BLANK_FRAMES - 1);

`ifdef VGA_MODE_CTRL_TIMEOUT_EN
  localparam logic [CNT_W-1:0] c_lock_last   = CNT_W'(LOCK_TIMEOUT - 1);
`else
  logic w_unused_lock;
  assign w_unused_lock = ^CNT_W'(LOCK_TIMEOUT);
`endif

  vga_state_e       r_state;
  logic [CNT_W-1:0] r_cnt;
  logic [CNT_W-1:0] r_frm;
  logic [1:0]       r_tgt;
  logic [1:0]       r_cur;
  vga_timing_t      r_tim;
  logic             r_ten;
  logic             r_blank;
  logic             r_err;
  logic             r_busy;
  logic             r_ready;
  logic             r_sync1;
  logic             r_sync2;

  logic             w_locked;
  logic [1:0]       w_tab_mode;
  vga_timing_t      w_tab;

  assign w_locked = r_sync2;

  // Only LOCK (timeout fallback) loads the reset mode; every other load is
  // the latched request.
  assign w_tab_mode = (r_state == ST_LOCK) ? c_reset_mode : r_tgt;

  vga_mode_table u_table (
    .i_mode     (w_tab_mode),
    .o_h_sync   (w_tab.h_sync),
    .o_h_back   (w_tab.h_back),
    .o_h_active (w_tab.h_active),
    .o_h_front  (w_tab.h_front),
    .o_v_sync   (w_tab.v_sync),
    .o_v_back   (w_tab.v_back),
    .o_v_active (w_tab.v_active),
    .o_v_front  (w_tab.v_front)
  );

  // Two-flop synchroniser for the asynchronous PLL lock indication
  always_ff @(posedge vga_clk or negedge rst_n) begin
    if (!rst_n) begin
      r_sync1 <= 1'b0;
      r_sync2 <= 1'b0;
    end else begin
      r_sync1 <= pll_locked;
      r_sync2 <= r_sync1;
    end
  end

  // Mode-switch sequencer with all outputs registered
  always_ff @(posedge vga_clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= ST_SETTLE;
      r_cnt   <= '0;
      r_frm   <= '0;
      r_tgt   <= c_reset_mode;
      r_cur   <= c_reset_mode;
      r_tim   <= mode_timing(c_reset_mode);
      r_ten   <= 1'b0;
      r_blank <= 1'b1;
      r_err   <= 1'b0;
      r_busy  <= 1'b1;
      r_ready <= 1'b0;
    end else begin
      case (r_state)
        ST_RUN: begin
          if (req_valid && r_ready) begin
            if (req_mode == MODE_ILLEGAL) begin
              r_err <= 1'b1;
            end else if (req_mode != r_cur) begin
              r_tgt   <= req_mode;
              r_state <= ST_DRAIN;
              r_ready <= 1'b0;
              r_busy  <= 1'b1;
            end
          end
        end

        // Let the visible frame finish before touching the clock
        ST_DRAIN: begin
          if (frame_end) begin
            r_state <= ST_SWITCH;
            r_cnt   <= '0;
            r_blank <= 1'b1;
            r_ten   <= 1'b0;
            r_cur   <= w_tab_mode;
            r_tim   <= w_tab;
          end
        end

        // Fixed 16-cycle window for the mux/PLL to react to the new select
        ST_SWITCH: begin
          if (r_cnt == c_switch_last) begin
            r_state <= ST_LOCK;
            r_cnt   <= '0;
          end else begin
            r_cnt <= sat_inc(r_cnt);
          end
        end

        ST_LOCK: begin
          if (w_locked) begin
            r_state <= ST_SETTLE;
            r_cnt   <= '0;
`ifdef VGA_MODE_CTRL_TIMEOUT_EN
          end else if (r_cnt == c_lock_last) begin
            // Give up on this mode; each expiry retries via SWITCH with the
            // reset mode.
            r_err   <= 1'b1;
            r_cur   <= w_tab_mode;
            r_tim   <= w_tab;
            r_state <= ST_SWITCH;
            r_cnt   <= '0;
`endif
          end else begin
            r_cnt <= sat_inc(r_cnt);
          end
        end

        // Settle time only accrues while the PLL is reported locked
        ST_SETTLE: begin
          if (!w_locked) begin
            r_cnt <= '0;
          end else if (r_cnt == c_settle_last) begin
            r_state <= ST_BLANKING;
            r_ten   <= 1'b1;
            r_cnt   <= '0;
            r_frm   <= '0;
          end else begin
            r_cnt <= sat_inc(r_cnt);
          end
        end

        // Hide the first frames of the new mode; lock loss restarts the relock
        ST_BLANKING: begin
          if (!w_locked) begin
            r_state <= ST_SWITCH;
            r_ten   <= 1'b0;
            r_cnt   <= '0;
          end else if (frame_end) begin
            if (r_frm == c_blank_last) begin
              r_state <= ST_RUN;
              r_blank <= 1'b0;
              r_busy  <= 1'b0;
              r_ready <= 1'b1;
            end else begin
              r_frm <= sat_inc(r_frm);
            end
          end
        end

        default: begin
          r_state <= ST_SETTLE;
          r_cnt   <= '0;
          r_ten   <= 1'b0;
          r_blank <= 1'b1;
          r_busy  <= 1'b1;
          r_ready <= 1'b0;
        end
      endcase
    end
  end

  assign req_ready = r_ready;
  assign clk_sel   = r_cur;
  assign cur_mode  = r_cur;
  assign timing_en = r_ten;
  assign blank     = r_blank;
  assign busy      = r_busy;
  assign err       = r_err;
  assign h_sync    = r_tim.h_sync;
  assign h_back    = r_tim.h_back;
  assign h_active  = r_tim.h_active;
  assign h_front   = r_tim.h_front;
  assign v_sync    = r_tim.v_sync;
  assign v_back    = r_tim.v_back;
  assign v_active  = r_tim.v_active;
  assign v_front   = r_tim.v_front;

endmodule
`default_nettype wire

// File: doc/vga_mode_ctrl.md
VGA_MODE_CTRL -- requirements
Module: vga_mode_ctrl

Interface
REQ-001 Parameters SHALL be, one per line:
- LOCK_TIMEOUT, 65000, max vga_clk cycles to wait for pll_locked high
- SETTLE_CYCLES, 256, vga_clk cycles after lock before timing_en rises
- BLANK_FRAMES, 2, frames with blank held high after a mode switch
- RESET_MODE, 2, mode loaded at reset (0=640x480, 1=800x600, 2=1024x768)
REQ-002 Ports SHALL be, one per line:
- vga_clk  in  1  pixel clock, glitch-free mux output, guaranteed running during relock
- rst_n  in  1  reset: asynchronous, active-low
- req_mode  in  2  requested mode code
- req_valid  in  1  mode request strobe
- req_ready  out  1  high only in RUN and no switch pending
- frame_end  in  1  one-cycle pulse from the sync generator at the last pixel of a frame
- pll_locked  in  1  PLL lock status (asynchronous; 2-flop synchronised internally)
- clk_sel  out  2  PLL/mux select, equal to the mode code
- timing_en  out  1  sync-generator enable; low holds its counters at 0
- blank  out  1  force RGB to black
- h_sync, h_back, h_active, h_front  out  11 each  horizontal timing of the current mode
- v_sync, v_back, v_active, v_front  out  11 each  vertical timing of the current mode
- cur_mode  out  2  mode currently applied
- busy  out  1  high in any state other than RUN
- err  out  1  sticky lock-timeout or illegal-request flag

Function
REQ-003 Mode table SHALL be (sync/back/active/front):
- mode 0: H 96/48/640/16; V 2/33/480/10
- mode 1: H 128/88/800/40; V 4/23/600/1
- mode 2: H 136/160/1024/24; V 6/29/768/3
- mode 3: illegal
REQ-004 FSM states SHALL be RUN, DRAIN, SWITCH, LOCK, SETTLE, BLANKING.
REQ-005 In RUN, a handshake (req_valid && req_ready) with a legal req_mode different from cur_mode SHALL latch req_mode and move to DRAIN next cycle.
REQ-006 A request equal to cur_mode SHALL be accepted and ignored; req_mode=3 SHALL be accepted, ignored, and set err.
REQ-007 DRAIN SHALL wait for frame_end; on that same cycle it SHALL drive blank=1 and move to SWITCH, so the switch never truncates a visible frame.
REQ-008 On SWITCH entry:
- timing_en SHALL go 0
- clk_sel SHALL take the latched mode
- the timing outputs and cur_mode SHALL update to the new mode
- SWITCH SHALL last exactly 16 cycles (mux/PLL reaction window) and then move to LOCK.
REQ-009 LOCK SHALL wait for synchronised pll_locked=1, then move to SETTLE; the cycle counter SHALL clear on entry.
REQ-010 SETTLE SHALL count SETTLE_CYCLES cycles and then assert timing_en=1, entering BLANKING.
REQ-011 BLANKING SHALL keep blank=1 until BLANK_FRAMES frame_end pulses have been counted, then deassert blank and return to RUN.
REQ-012 In BLANKING, synchronised pll_locked falling SHALL return the FSM to SWITCH (relock path) with timing_en=0.
REQ-013 req_valid outside RUN SHALL be ignored (req_ready=0); requests are not queued.
REQ-014 Counters SHALL be 17 bits wide and saturate, never wrap.
REQ-015 All outputs SHALL be registered; the latency from the accepting handshake to DRAIN is 1 cycle.

Reset
REQ-016 Reset SHALL set:
- state=SETTLE, timing_en=0, blank=1, err=0, busy=1, req_ready=0
- cur_mode, clk_sel and the timing outputs = RESET_MODE values
- counters=0.
REQ-017 Reset mid-switch SHALL abandon the switch and restart from RESET_MODE; SETTLE SHALL still require a synchronised pll_locked=1 before counting.

Configuration
REQ-018 With VGA_MODE_CTRL_TIMEOUT_EN defined, LOCK SHALL leave after LOCK_TIMEOUT cycles without lock: set err, restore clk_sel and the timing outputs to RESET_MODE, and re-enter SWITCH once.
REQ-019 With VGA_MODE_CTRL_TIMEOUT_EN undefined, LOCK SHALL wait indefinitely and err SHALL be set only by illegal requests.

Structure
REQ-020 Package vga_pkg SHALL hold the mode codes, the per-mode timing constants and the FSM state enumeration.
REQ-021 The mode lookup SHALL be a combinational sub-module vga_mode_table (mode in, eight 11-bit timings out).

Verification
REQ-022 Reset, pll_locked=1 -> 256 cycles later timing_en=1; blank clears after 2 frame_end pulses; h_active=1024.
REQ-023 In RUN, req_mode=0 -> DRAIN until frame_end; then clk_sel=0, timing_en=0, h_active=640 and v_front=10; after lock plus 256 cycles timing_en=1.
REQ-024 req_mode=3 in RUN -> err=1, cur_mode unchanged, busy stays 0.
REQ-025 With the macro defined, LOCK_TIMEOUT=100 and pll_locked held 0 -> err=1 at cycle 100 of LOCK; clk_sel returns to 2.
REQ-026 pll_locked drops during BLANKING -> timing_en=0 next-but-two cycle (sync delay), FSM returns to SWITCH.
REQ-027 req_valid held during DRAIN with a different mode -> ignored; the final mode equals the first request.
